// File: rtl/can_clic_dispatch_if.sv
// Bundle between the CLIC arbiter, the core request port and the pending-entry clear path.
interface can_clic_dispatch_if #(
  parameter int N_ENTRIES   = 4,
  parameter int INDEX_W     = $clog2(N_ENTRIES),
  parameter int PRIO_W      = 2,
  parameter int STACK_DEPTH = 3
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               arb_is_interrupt;
  logic [INDEX_W-1:0] arb_index;
  logic [PRIO_W-1:0]  arb_prio;
  logic               irq_req;
  logic [INDEX_W-1:0] irq_index;
  logic               irq_ack;
  logic               irq_ret;
  logic               clr_pending;
  logic [INDEX_W-1:0] clr_index;
  logic [PRIO_W-1:0]  cur_prio;
  logic [DEPTH_W-1:0] depth;
  logic               err;

  modport slave (
    input  arb_is_interrupt, arb_index, arb_prio, irq_ack, irq_ret,
    output irq_req, irq_index, clr_pending, clr_index, cur_prio, depth, err
  );

  modport master (
    output arb_is_interrupt, arb_index, arb_prio, irq_ack, irq_ret,
    input  irq_req, irq_index, clr_pending, clr_index, cur_prio, depth, err
  );
endinterface

// File: rtl/can_clic_dispatch.sv
// CLIC dispatch stage: req/ack to the core, pending clear pulse, nested priority stack.
// Optional CAN_CLIC_REQ_UPDATE_EN lets a higher-priority winner replace an unacked request.
module can_clic_dispatch #(
  parameter int N_ENTRIES   = 4,
  parameter int INDEX_W     = $clog2(N_ENTRIES),
  parameter int PRIO_W      = 2,
  parameter int STACK_DEPTH = 3
) (
  input logic                clk,
  input logic                rst_n,
  can_clic_dispatch_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int SLOTS   = 2 ** DEPTH_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CLR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [PRIO_W-1:0]  prio_q, prio_d;
  logic [PRIO_W-1:0]  cur_prio_q, cur_prio_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic [PRIO_W-1:0]  stack_q [SLOTS];
  logic [PRIO_W-1:0]  stack_d [SLOTS];

  logic               dispatch_ok;
  logic [DEPTH_W-1:0] top;

  assign dispatch_ok = bus.arb_is_interrupt && (bus.arb_prio > cur_prio_q) &&
                       (depth_q < DEPTH_W'(STACK_DEPTH));
  assign top         = depth_q - DEPTH_W'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    prio_d     = prio_q;
    cur_prio_d = cur_prio_q;
    depth_d    = depth_q;
    err_d      = err_q;
    stack_d    = stack_q;

    unique case (state_q)
      IDLE: begin
        if (dispatch_ok) begin
          idx_d   = bus.arb_index;
          prio_d  = bus.arb_prio;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          stack_d[depth_q] = cur_prio_q;
          cur_prio_d       = prio_q;
          depth_d          = depth_q + DEPTH_W'(1);
          state_d          = CLR;
        end
`ifdef CAN_CLIC_REQ_UPDATE_EN
        else if (dispatch_ok && (bus.arb_prio > prio_q)) begin
          idx_d  = bus.arb_index;
          prio_d = bus.arb_prio;
        end
`endif
      end
      CLR: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A return colliding with an accepted ack is dropped so the push wins.
    if (bus.irq_ret) begin
      if ((state_q == REQ) && bus.irq_ack) begin
        err_d = 1'b1;
      end else if (depth_q == '0) begin
        err_d = 1'b1;
      end else begin
        cur_prio_d = stack_q[top];
        depth_d    = top;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      prio_q     <= '0;
      cur_prio_q <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prio_q     <= prio_d;
      cur_prio_q <= cur_prio_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
      stack_q    <= stack_d;
    end
  end

  assign bus.irq_req     = (state_q == REQ);
  assign bus.irq_index   = idx_q;
  assign bus.clr_pending = (state_q == CLR);
  assign bus.clr_index   = idx_q;
  assign bus.cur_prio    = cur_prio_q;
  assign bus.depth       = depth_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_can_clic_dispatch.sv
// Directed bench for can_clic_dispatch: one vector per clock plus reset/collision/update/full sequences.
module tb_can_clic_dispatch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  can_clic_dispatch_if #(.N_ENTRIES(4), .PRIO_W(2), .STACK_DEPTH(3)) bus0 ();
  can_clic_dispatch_if #(.N_ENTRIES(4), .PRIO_W(2), .STACK_DEPTH(1)) bus1 ();

  can_clic_dispatch #(.N_ENTRIES(4), .PRIO_W(2), .STACK_DEPTH(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  can_clic_dispatch #(.N_ENTRIES(4), .PRIO_W(2), .STACK_DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

`ifdef CAN_CLIC_REQ_UPDATE_EN
  localparam int UPD_IDX = 0;
  localparam int UPD_PRIO = 3;
`else
  localparam int UPD_IDX = 2;
  localparam int UPD_PRIO = 1;
`endif

  // inputs: v idx prio ack ret | expected after the edge: req iidx clr cidx cur dep err
  typedef struct {
    int v, idx, prio, ack, ret;
    int req, iidx, clr, cidx, cur, dep, err;
  } vec_t;

  int applied = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input int which, input vec_t t);
    if (which == 0) begin
      bus0.arb_is_interrupt = 1'(t.v);
      bus0.arb_index        = 2'(t.idx);
      bus0.arb_prio         = 2'(t.prio);
      bus0.irq_ack          = 1'(t.ack);
      bus0.irq_ret          = 1'(t.ret);
    end else begin
      bus1.arb_is_interrupt = 1'(t.v);
      bus1.arb_index        = 2'(t.idx);
      bus1.arb_prio         = 2'(t.prio);
      bus1.irq_ack          = 1'(t.ack);
      bus1.irq_ret          = 1'(t.ret);
    end
  endtask

  task automatic apply(input int which, input vec_t t, input string tag);
    logic [31:0] req, iidx, clr, cidx, cur, dep, err;
    drive(which, t);
    @(posedge clk);
    #1;
    if (which == 0) begin
      req = 32'(bus0.irq_req);   iidx = 32'(bus0.irq_index);
      clr = 32'(bus0.clr_pending); cidx = 32'(bus0.clr_index);
      cur = 32'(bus0.cur_prio);  dep = 32'(bus0.depth); err = 32'(bus0.err);
    end else begin
      req = 32'(bus1.irq_req);   iidx = 32'(bus1.irq_index);
      clr = 32'(bus1.clr_pending); cidx = 32'(bus1.clr_index);
      cur = 32'(bus1.cur_prio);  dep = 32'(bus1.depth); err = 32'(bus1.err);
    end
    chk({tag, ".irq_req"}, req, t.req);
    if (t.req != 0) chk({tag, ".irq_index"}, iidx, t.iidx);
    chk({tag, ".clr_pending"}, clr, t.clr);
    if (t.clr != 0) chk({tag, ".clr_index"}, cidx, t.cidx);
    chk({tag, ".cur_prio"}, cur, t.cur);
    chk({tag, ".depth"}, dep, t.dep);
    chk({tag, ".err"}, err, t.err);
  endtask

  task automatic pulse_reset();
    drive(0, '{0,0,0,0,0, 0,0,0,0,0,0,0});
    drive(1, '{0,0,0,0,0, 0,0,0,0,0,0,0});
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  vec_t tbl [19];
  vec_t z;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    z = '{0,0,0,0,0, 0,0,0,0,0,0,0};
    tbl = '{
      '{1,3,2,0,0, 1,3,0,0,0,0,0},  // dispatch idx3 p2
      '{1,3,2,1,0, 0,0,1,3,2,1,0},  // ack -> CLR, push 0
      '{1,1,3,0,0, 0,0,0,0,2,1,0},  // higher winner during CLR is blanked
      '{1,1,3,0,0, 1,1,0,0,2,1,0},  // earliest re-request t+3
      '{1,1,3,1,0, 0,0,1,1,3,2,0},  // nested ack
      '{0,0,0,1,0, 0,0,0,0,3,2,0},  // stray ack in IDLE: no error
      '{0,0,0,0,1, 0,0,0,0,2,1,0},  // return
      '{0,0,0,0,1, 0,0,0,0,0,0,0},  // return
      '{0,0,0,0,1, 0,0,0,0,0,0,1},  // underflow return
      '{0,0,0,0,0, 0,0,0,0,0,0,1},  // err sticky
      '{1,2,2,0,0, 1,2,0,0,0,0,1},
      '{1,2,2,1,0, 0,0,1,2,2,1,1},
      '{1,0,2,0,0, 0,0,0,0,2,1,1},
      '{1,0,2,0,0, 0,0,0,0,2,1,1},  // equal prio masked
      '{1,1,3,0,0, 1,1,0,0,2,1,1},
      '{1,1,3,0,1, 1,1,0,0,0,0,1},  // return while REQ: pop, req stays
      '{1,1,3,1,0, 0,0,1,1,3,1,1},
      '{0,0,0,0,1, 0,0,0,0,0,0,1},  // return during CLR
      '{0,0,0,0,0, 0,0,0,0,0,0,1}
    };

    drive(0, z);
    drive(1, z);
    rst_n = 1'b0;
    #8;
    chk("rst.irq_req", 32'(bus0.irq_req), 0);
    chk("rst.irq_index", 32'(bus0.irq_index), 0);
    chk("rst.clr_pending", 32'(bus0.clr_pending), 0);
    chk("rst.clr_index", 32'(bus0.clr_index), 0);
    chk("rst.cur_prio", 32'(bus0.cur_prio), 0);
    chk("rst.depth", 32'(bus0.depth), 0);
    chk("rst.err", 32'(bus0.err), 0);
    #4;
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      apply(0, tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a request
    apply(0, '{1,3,2,0,0, 1,3,0,0,0,0,1}, "ar0");
    apply(0, '{1,3,2,1,0, 0,0,1,3,2,1,1}, "ar1");
    apply(0, '{0,0,0,0,0, 0,0,0,0,2,1,1}, "ar2");
    apply(0, '{1,1,3,0,0, 1,1,0,0,2,1,1}, "ar3");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.irq_req", 32'(bus0.irq_req), 0);
    chk("arst.irq_index", 32'(bus0.irq_index), 0);
    chk("arst.clr_pending", 32'(bus0.clr_pending), 0);
    chk("arst.cur_prio", 32'(bus0.cur_prio), 0);
    chk("arst.depth", 32'(bus0.depth), 0);
    chk("arst.err", 32'(bus0.err), 0);
    drive(0, z);
    #2;
    rst_n = 1'b1;
    apply(0, '{0,0,0,0,0, 0,0,0,0,0,0,0}, "ar_idle");
    apply(0, '{1,2,1,0,0, 1,2,0,0,0,0,0}, "ar_req");

    // ack and return in the same REQ cycle
    apply(0, '{1,2,1,1,1, 0,0,1,2,1,1,1}, "coll");

    // Replacement of an unacked request by a higher winner
    pulse_reset();
    apply(0, '{1,2,1,0,0, 1,2,0,0,0,0,0}, "upd0");
    apply(0, '{1,0,3,0,0, 1,UPD_IDX,0,0,0,0,0}, "upd1");
    apply(0, '{0,0,0,0,0, 1,UPD_IDX,0,0,0,0,0}, "upd2");
    apply(0, '{0,0,0,1,0, 0,0,1,UPD_IDX,UPD_PRIO,1,0}, "upd3");

    // Single-level stack: masking then full-stack hold until return
    pulse_reset();
    apply(1, '{1,0,2,0,0, 1,0,0,0,0,0,0}, "s1_req");
    apply(1, '{1,0,2,1,0, 0,0,1,0,2,1,0}, "s1_ack");
    for (int i = 0; i < 10; i++) begin
      apply(1, '{1,0,2,0,0, 0,0,0,0,2,1,0}, $sformatf("s1_mask%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      apply(1, '{1,3,3,0,0, 0,0,0,0,2,1,0}, $sformatf("s1_full%0d", i));
    end
    apply(1, '{1,3,3,0,1, 0,0,0,0,0,0,0}, "s1_ret");
    apply(1, '{1,3,3,0,0, 1,3,0,0,0,0,0}, "s1_redisp");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
